// File: rtl/demux_frame_sequencer_if.sv
// ============================================================================
// Module : demux_frame_sequencer_if
// Brief  : Handshake and demux-drive bundle between a word source and the
//          frame sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface demux_frame_sequencer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       hold;
  logic       D;
  logic [2:0] S;
  logic       d_valid;
  logic       frame_done;
  logic       busy;

  modport master (
    output in_valid, in_data, hold,
    input  in_ready, D, S, d_valid, frame_done, busy
  );

  modport slave (
    input  in_valid, in_data, hold,
    output in_ready, D, S, d_valid, frame_done, busy
  );
endinterface

`default_nettype wire

// File: rtl/demux_frame_sequencer.sv
// ============================================================================
// Module : demux_frame_sequencer
// Brief  : Plays an accepted 8-bit word out one bit per cycle with the
//          matching 1-to-8 demux select, with optional inter-frame gap.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module demux_frame_sequencer #(
  parameter int GAP_CYCLES = 0,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  demux_frame_sequencer_if.slave bus_io
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] word_q, word_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gap_q, gap_d;

  logic w_live;
  logic w_last;
  logic w_ready;
  logic w_accept;

  function automatic logic [2:0] slot_sel(input logic [2:0] c);
    return MSB_FIRST ? ~c : c;
  endfunction

  // hold acts on the slot being presented in the same cycle
  assign w_live   = (state_q == S_SEND) & ~bus_io.hold;
  assign w_last   = w_live & (cnt_q == 3'd7);
  assign w_ready  = ~rst & ((state_q == S_IDLE) | ((GAP_CYCLES == 0) & w_last));
  assign w_accept = bus_io.in_valid & w_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    sel_d   = sel_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          state_d = S_SEND;
          cnt_d   = 3'd0;
          word_d  = bus_io.in_data;
          sel_d   = slot_sel(3'd0);
        end
      end
      S_SEND: begin
        if (w_live) begin
          if (cnt_q == 3'd7) begin
            if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              gap_d   = 8'd0;
            end else if (w_accept) begin
              cnt_d  = 3'd0;
              word_d = bus_io.in_data;
              sel_d  = slot_sel(3'd0);
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
            sel_d = slot_sel(cnt_q + 3'd1);
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      word_q  <= 8'd0;
      sel_q   <= 3'd0;
      gap_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      gap_q   <= gap_d;
    end
  end

  // S keeps its last slot outside live cycles so the demux sees a stable select
  assign bus_io.in_ready   = w_ready;
  assign bus_io.D          = w_live & word_q[sel_q];
  assign bus_io.S          = sel_q;
  assign bus_io.d_valid    = w_live;
  assign bus_io.frame_done = w_last;
  assign bus_io.busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire
